// File: rtl/pc_word_parser.sv
// PC word parser: decodes 24-bit PC words by opcode into register writes,
// per-channel one-entry config buffers, or a two-word BD head/tail assembly.
module pc_word_parser #(
  parameter int NPCin   = 24,
  parameter int NBDdata = 21,
  parameter int Nleaf   = 5,
  parameter int Nconf   = 16,
  parameter int Nreg    = 32,
  parameter int Nchan   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NPCin-1:0]       PC_in_d,
  input  logic                   PC_in_v,
  output logic                   PC_in_a,
  input  logic [Nreg*Nconf-1:0]  conf_reg_reset_vals,
  output logic [Nreg*Nconf-1:0]  conf_reg_out,
  output logic [Nchan*Nconf-1:0] conf_chan_d,
  output logic [Nchan-1:0]       conf_chan_v,
  input  logic [Nchan-1:0]       conf_chan_a,
  output logic [Nleaf-1:0]       BD_leaf_code,
  output logic [NBDdata-1:0]     BD_payload,
  output logic                   BD_v,
  input  logic                   BD_a,
  output logic                   parse_err,
  output logic                   state_dbg
);

  localparam int NPHI = NBDdata - Nconf;

  typedef enum logic {IDLE = 1'b0, HEAD_PENDING = 1'b1} state_t;

  state_t            state;
  logic [Nleaf-1:0]  leaf_q;
  logic [NPHI-1:0]   phi_q;

  logic [1:0]        op;
  logic [5:0]        f;
  logic [Nconf-1:0]  data;
  logic              reg_ok;
  logic              chan_ok;
  logic              chan_full;
  logic              accept;

  assign op   = PC_in_d[NPCin-1 -: 2];
  assign f    = PC_in_d[NPCin-3 -: 6];
  assign data = PC_in_d[Nconf-1:0];

  assign state_dbg = (state == HEAD_PENDING);

  // Every channel transfers on a rising edge where v && a; a raised valid
  // keeps its data stable until acked. PC_in_a never looks at any output ack.
  always_comb begin
    reg_ok    = ({1'b0, f} < 7'(Nreg));
    chan_ok   = ({1'b0, f} < 7'(Nchan));
    chan_full = 1'b0;
    for (int c = 0; c < Nchan; c++) begin
      if (f == 6'(c)) chan_full = conf_chan_v[c];
    end
    case (op)
      2'b00:   PC_in_a = 1'b1;
      2'b01:   PC_in_a = chan_ok ? !chan_full : 1'b1;
      2'b10:   PC_in_a = 1'b1;
      default: PC_in_a = (state == IDLE) ? 1'b1 : !BD_v;
    endcase
  end

  assign accept = PC_in_v && PC_in_a;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conf_reg_out <= conf_reg_reset_vals;
      conf_chan_d  <= '0;
      conf_chan_v  <= '0;
      BD_leaf_code <= '0;
      BD_payload   <= '0;
      BD_v         <= 1'b0;
      parse_err    <= 1'b0;
      leaf_q       <= '0;
      phi_q        <= '0;
      state        <= IDLE;
    end else begin
      for (int c = 0; c < Nchan; c++) begin
        if (conf_chan_v[c] && conf_chan_a[c]) conf_chan_v[c] <= 1'b0;
      end
      if (BD_v && BD_a) BD_v <= 1'b0;

      if (accept) begin
        case (op)
          2'b00: begin
            if (reg_ok) begin
              for (int r = 0; r < Nreg; r++) begin
                if (f == 6'(r)) conf_reg_out[r*Nconf +: Nconf] <= data;
              end
            end else begin
              parse_err <= 1'b1;
            end
          end
          2'b01: begin
            // The ack rule guarantees the addressed slot is empty here.
            if (chan_ok) begin
              for (int c = 0; c < Nchan; c++) begin
                if (f == 6'(c)) begin
                  conf_chan_d[c*Nconf +: Nconf] <= data;
                  conf_chan_v[c]                <= 1'b1;
                end
              end
            end else begin
              parse_err <= 1'b1;
            end
          end
          2'b10: begin
            if (state == HEAD_PENDING) parse_err <= 1'b1;
            leaf_q <= f[Nleaf-1:0];
            phi_q  <= data[NPHI-1:0];
            state  <= HEAD_PENDING;
          end
          default: begin
            if (state == IDLE) begin
              parse_err <= 1'b1;
            end else begin
              BD_leaf_code <= leaf_q;
              BD_payload   <= {phi_q, data};
              BD_v         <= 1'b1;
              state        <= IDLE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_word_parser.sv
// Bench for pc_word_parser: register-write/error vector table, plus
// hand-written channel and BD sequences checked through expected queues.
module tb_pc_word_parser;

  localparam int NREG  = 32;
  localparam int NCHAN = 2;
  localparam int NCONF = 16;

  logic                   clk;
  logic                   reset;
  logic [23:0]            PC_in_d;
  logic                   PC_in_v;
  logic                   PC_in_a;
  logic [NREG*NCONF-1:0]  conf_reg_reset_vals;
  logic [NREG*NCONF-1:0]  conf_reg_out;
  logic [NCHAN*NCONF-1:0] conf_chan_d;
  logic [NCHAN-1:0]       conf_chan_v;
  logic [NCHAN-1:0]       conf_chan_a;
  logic [4:0]             BD_leaf_code;
  logic [20:0]            BD_payload;
  logic                   BD_v;
  logic                   BD_a;
  logic                   parse_err;
  logic                   state_dbg;

  pc_word_parser dut (
    .clk                 (clk),
    .reset               (reset),
    .PC_in_d             (PC_in_d),
    .PC_in_v             (PC_in_v),
    .PC_in_a             (PC_in_a),
    .conf_reg_reset_vals (conf_reg_reset_vals),
    .conf_reg_out        (conf_reg_out),
    .conf_chan_d         (conf_chan_d),
    .conf_chan_v         (conf_chan_v),
    .conf_chan_a         (conf_chan_a),
    .BD_leaf_code        (BD_leaf_code),
    .BD_payload          (BD_payload),
    .BD_v                (BD_v),
    .BD_a                (BD_a),
    .parse_err           (parse_err),
    .state_dbg           (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [15:0] exp_chan0_q[$];
  logic [15:0] exp_chan1_q[$];
  logic [25:0] exp_q[$];
  logic [15:0] exp_regs[NREG];
  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    bit          pre_reset;
    logic [23:0] word;
    int          reg_idx;
    logic [15:0] reg_val;
    bit          exp_err;
  } vec_t;
  vec_t vecs[10];

  function automatic logic [15:0] rv(input int r);
    if (r == 23) return 16'h1388;
    return 16'(r * 257);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) exp_regs[r] = rv(r);
  endtask

  task automatic chk_regs(input string tag);
    for (int r = 0; r < NREG; r++)
      chk($sformatf("%s_reg%0d", tag, r), 32'(conf_reg_out[r*NCONF +: NCONF]), 32'(exp_regs[r]));
  endtask

  // Output monitor: a v && a seen at the negedge completes on the next posedge.
  task automatic mon();
    if (conf_chan_v[0] && conf_chan_a[0]) begin
      if (exp_chan0_q.size() == 0) chk("chan0_unexpected", 32'(exp_chan0_q.size()), 32'd1);
      else chk("chan0_data", 32'(conf_chan_d[15:0]), 32'(exp_chan0_q.pop_front()));
    end
    if (conf_chan_v[1] && conf_chan_a[1]) begin
      if (exp_chan1_q.size() == 0) chk("chan1_unexpected", 32'(exp_chan1_q.size()), 32'd1);
      else chk("chan1_data", 32'(conf_chan_d[31:16]), 32'(exp_chan1_q.pop_front()));
    end
    if (BD_v && BD_a) begin
      if (exp_q.size() == 0) chk("bd_unexpected", 32'(exp_q.size()), 32'd1);
      else chk("bd_word", 32'({BD_leaf_code, BD_payload}), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    mon();
  endtask

  task automatic at_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    at_neg();
    at_pos();
  endtask

  task automatic apply_reset();
    PC_in_v     = 1'b0;
    conf_chan_a = '0;
    BD_a        = 1'b0;
    #2 reset = 1'b0;
    at_pos();
    at_pos();
    reset = 1'b1;
    model_reset();
  endtask

  // driver: holds the word until accepted, returns cycles spent stalled
  task automatic send_word(input logic [23:0] w, output int waits);
    bit done;
    PC_in_d = w;
    PC_in_v = 1'b1;
    waits   = 0;
    done    = 1'b0;
    while (!done) begin
      at_neg();
      if (PC_in_a) begin
        done = 1'b1;
      end else begin
        waits++;
        if (waits >= 20) begin
          chk($sformatf("send_timeout_%06h", w), 32'(waits), 32'd0);
          done = 1'b1;
        end
      end
      at_pos();
    end
    PC_in_v = 1'b0;
  endtask

  initial begin
    int w;
    reset       = 1'b0;
    PC_in_d     = '0;
    PC_in_v     = 1'b0;
    conf_chan_a = '0;
    BD_a        = 1'b0;
    for (int r = 0; r < NREG; r++) conf_reg_reset_vals[r*NCONF +: NCONF] = rv(r);
    model_reset();

    vecs[0] = '{1'b0, 24'h031234, 3,  16'h1234, 1'b0};
    vecs[1] = '{1'b0, 24'h1FFFFF, 31, 16'hFFFF, 1'b0};
    vecs[2] = '{1'b0, 24'h00A5A5, 0,  16'hA5A5, 1'b0};
    vecs[3] = '{1'b0, 24'h170000, 23, 16'h0000, 1'b0};
    vecs[4] = '{1'b0, 24'h030042, 3,  16'h0042, 1'b0};
    vecs[5] = '{1'b1, 24'hC00001, -1, 16'h0000, 1'b1};
    vecs[6] = '{1'b1, 24'h280000, -1, 16'h0000, 1'b1};
    vecs[7] = '{1'b1, 24'h200000, -1, 16'h0000, 1'b1};
    vecs[8] = '{1'b1, 24'h420000, -1, 16'h0000, 1'b1};
    vecs[9] = '{1'b1, 24'h7F0000, -1, 16'h0000, 1'b1};

    at_pos();
    at_pos();
    reset = 1'b1;
    at_pos();

    // reset state
    chk("rst_reg0", 32'(conf_reg_out[0 +: 16]), 32'h0000);
    chk("rst_reg23", 32'(conf_reg_out[23*16 +: 16]), 32'h1388);
    chk_regs("rst");
    chk("rst_chan_v", 32'(conf_chan_v), 32'd0);
    chk("rst_bd_v", 32'(BD_v), 32'd0);
    chk("rst_err", 32'(parse_err), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);

    // register writes and decode errors
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].pre_reset) apply_reset();
      send_word(vecs[i].word, w);
      chk($sformatf("vec%0d_ack", i), 32'(w), 32'd0);
      if (vecs[i].reg_idx >= 0) exp_regs[vecs[i].reg_idx] = vecs[i].reg_val;
      chk_regs($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_err", i), 32'(parse_err), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_chan_v", i), 32'(conf_chan_v), 32'd0);
      chk($sformatf("vec%0d_bd_v", i), 32'(BD_v), 32'd0);
      chk($sformatf("vec%0d_state", i), 32'(state_dbg), 32'd0);
    end

    // channel buffering, per-channel stall, bypass to a free channel
    apply_reset();
    send_word(24'h40ABCD, w);
    chk("chan0_first_ack", 32'(w), 32'd0);
    exp_chan0_q.push_back(16'hABCD);
    chk("chan0_v", 32'(conf_chan_v[0]), 32'd1);
    chk("chan0_d", 32'(conf_chan_d[15:0]), 32'hABCD);
    send_word(24'h411111, w);
    chk("chan1_bypass_ack", 32'(w), 32'd0);
    exp_chan1_q.push_back(16'h1111);
    chk("chan_both_v", 32'(conf_chan_v), 32'd3);
    PC_in_d = 24'h405555;
    PC_in_v = 1'b1;
    for (int i = 0; i < 4; i++) begin
      at_neg();
      chk($sformatf("chan0_stall%0d", i), 32'(PC_in_a), 32'd0);
      at_pos();
    end
    conf_chan_a[0] = 1'b1;
    at_neg();
    chk("chan0_same_cycle_stall", 32'(PC_in_a), 32'd0);
    at_pos();
    chk("chan0_cleared", 32'(conf_chan_v[0]), 32'd0);
    at_neg();
    chk("chan0_reaccept", 32'(PC_in_a), 32'd1);
    at_pos();
    PC_in_v = 1'b0;
    exp_chan0_q.push_back(16'h5555);
    chk("chan0_d2", 32'(conf_chan_d[15:0]), 32'h5555);
    conf_chan_a = 2'b11;
    step();
    conf_chan_a = 2'b00;
    chk("chan_drained_v", 32'(conf_chan_v), 32'd0);
    chk("chan_err", 32'(parse_err), 32'd0);

    // BD head/tail assembly, tail stalls while the BD slot is full
    send_word(24'h8A0015, w);
    chk("bd_head_ack", 32'(w), 32'd0);
    chk("bd_head_state", 32'(state_dbg), 32'd1);
    chk("bd_head_no_v", 32'(BD_v), 32'd0);
    send_word(24'hC0BEEF, w);
    chk("bd_tail_ack", 32'(w), 32'd0);
    exp_q.push_back({5'd10, 21'h15BEEF});
    chk("bd_v", 32'(BD_v), 32'd1);
    chk("bd_leaf", 32'(BD_leaf_code), 32'd10);
    chk("bd_payload", 32'(BD_payload), 32'h15BEEF);
    chk("bd_state_idle", 32'(state_dbg), 32'd0);
    send_word(24'h8A0033, w);
    chk("bd_head2_ack", 32'(w), 32'd0);
    PC_in_d = 24'hC01234;
    PC_in_v = 1'b1;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk($sformatf("bd_tail_stall%0d", i), 32'(PC_in_a), 32'd0);
      at_pos();
    end
    BD_a = 1'b1;
    at_neg();
    chk("bd_same_cycle_stall", 32'(PC_in_a), 32'd0);
    at_pos();
    at_neg();
    chk("bd_tail_reaccept", 32'(PC_in_a), 32'd1);
    at_pos();
    PC_in_v = 1'b0;
    exp_q.push_back({5'd10, 21'h131234});
    step();
    BD_a = 1'b0;
    chk("bd_drained_v", 32'(BD_v), 32'd0);
    chk("bd_err", 32'(parse_err), 32'd0);

    // head overwritten by a second head
    apply_reset();
    send_word(24'h8A0001, w);
    chk("hh_err_before", 32'(parse_err), 32'd0);
    send_word(24'h8B0002, w);
    chk("hh_err_after", 32'(parse_err), 32'd1);
    send_word(24'hC00003, w);
    exp_q.push_back({5'd11, 21'h020003});
    chk("hh_leaf", 32'(BD_leaf_code), 32'd11);
    chk("hh_payload", 32'(BD_payload), 32'h020003);
    BD_a = 1'b1;
    step();
    BD_a = 1'b0;
    chk("hh_drained_v", 32'(BD_v), 32'd0);

    // reset between head and tail discards the head
    apply_reset();
    send_word(24'h050777, w);
    exp_regs[5] = 16'h0777;
    chk("mid_reg5", 32'(conf_reg_out[5*16 +: 16]), 32'h0777);
    send_word(24'h8A0015, w);
    chk("mid_state", 32'(state_dbg), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_state", 32'(state_dbg), 32'd0);
    chk("async_rst_reg5", 32'(conf_reg_out[5*16 +: 16]), 32'(rv(5)));
    at_pos();
    reset = 1'b1;
    model_reset();
    send_word(24'hC0BEEF, w);
    chk("mid_tail_ack", 32'(w), 32'd0);
    chk("mid_bd_v", 32'(BD_v), 32'd0);
    chk("mid_err", 32'(parse_err), 32'd1);
    chk_regs("mid");
    step();
    chk("mid_bd_v_later", 32'(BD_v), 32'd0);

    // final report
    chk("q_chan0_empty", 32'(exp_chan0_q.size()), 32'd0);
    chk("q_chan1_empty", 32'(exp_chan1_q.size()), 32'd0);
    chk("q_bd_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_word_parser.md
Name: pc_word_parser

Overview:
Upstream stage of the PC configuration mapper. It accepts 24-bit words from the PC input channel and decodes them by a 2-bit opcode into one of three destinations:
- the configuration register file (conf_reg_out),
- one of Nchan serial config channels (conf_chan_*),
- a two-word BD passthrough assembled into one BD word.

The mapper consumes conf_reg_out and conf_chan_* and returns conf_reg_reset_vals.

Parameters:
NPCin, 24, PC word width; must equal 2+6+Nconf
NBDdata, 21, BD payload width; NBDdata-Nconf must be ≤ Nconf
Nleaf, 5, BD leaf code width; ≤ 6
Nconf, 16, config register / channel data width
Nreg, 32, number of config registers; ≤ 64
Nchan, 2, number of config channels; ≤ 64

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
PC_in_d  in  NPCin  PC word
PC_in_v  in  1  PC word valid
PC_in_a  out  1  PC word accepted (ack)
conf_reg_reset_vals  in  Nreg*Nconf  reset value per register (constant, driven by mapper)
conf_reg_out  out  Nreg*Nconf  config registers, register r at [r*Nconf +: Nconf]
conf_chan_d  out  Nchan*Nconf  channel data, channel c at [c*Nconf +: Nconf]
conf_chan_v  out  Nchan  channel valid
conf_chan_a  in  Nchan  channel ack
BD_leaf_code  out  Nleaf  BD word leaf code
BD_payload  out  NBDdata  BD word payload
BD_v  out  1  BD word valid
BD_a  in  1  BD word ack
parse_err  out  1  sticky decode error flag

Behaviour:
- Handshake (all channels): a transfer occurs on a rising edge where v && a. A valid is held with stable data until it is acked.
- Reset (reset low, asynchronous):
  - conf_reg_out = conf_reg_reset_vals.
  - conf_chan_v = 0, BD_v = 0, parse_err = 0.
  - Head-pending state cleared.
  - Data outputs reset to 0.
- Opcode op = PC_in_d[23:22]; field f = PC_in_d[21:16]; data = PC_in_d[15:0].
- op 00, register write:
  - PC_in_a = 1.
  - If f < Nreg, register[f] <= data, visible the cycle after acceptance.
  - If f ≥ Nreg, the word is dropped and parse_err <= 1.
- op 01, channel write:
  - If f ≥ Nchan: PC_in_a = 1, word dropped, parse_err <= 1.
  - Else PC_in_a = !conf_chan_v[f]. On acceptance conf_chan_d[f] <= data and conf_chan_v[f] <= 1, next cycle.
  - conf_chan_v[c] clears on the cycle after its handshake.
  - One-entry buffer per channel. A full channel stalls only words addressed to it.
- op 10, BD head:
  - PC_in_a = 1.
  - Latch leaf = f[Nleaf-1:0] and phi = data[NBDdata-Nconf-1:0]; state -> HEAD_PENDING.
  - A head arriving while already HEAD_PENDING overwrites the old head and sets parse_err <= 1.
- op 11, BD tail:
  - In IDLE: PC_in_a = 1, word dropped, parse_err <= 1.
  - In HEAD_PENDING: PC_in_a = !BD_v. On acceptance:
    - BD_leaf_code <= leaf
    - BD_payload <= {phi, data}
    - BD_v <= 1
    - state -> IDLE
- BD_v clears after its handshake.
- State machine: IDLE, HEAD_PENDING. Only op 10 and op 11 change state; op 00 and op 01 are processed in either state.
- Timing:
  - PC_in_a is combinational from PC_in_d, state and output valids only. There is no combinational path from conf_chan_a or BD_a.
  - Throughput: 1 word/cycle, except back-to-back words to one destination, which take 2 cycles each.
- Simultaneous events: an output handshake and a new word to the same slot in the same cycle is not accepted (the ack rule forbids it). The slot is accepted the following cycle.
- parse_err is cleared only by reset.
- Reset mid-sequence: a pending head is discarded and pending outputs are dropped.

Test Plan:
1. Reset, then release -> conf_reg_out equals conf_reg_reset_vals (reg0 = 0x0000, reg23 = 0x1388); all v = 0; parse_err = 0.
2. Word 0x031234 -> one cycle after accept, reg3 = 0x1234; all other registers unchanged; PC_in_a = 1.
3. 0x40ABCD, then 0x405555, then 0x411111, with conf_chan_a[0] held 0 for 5 cycles ->
   - conf_chan_v[0] = 1 with 0xABCD.
   - 0x405555 stalls (PC_in_a = 0) until chan0 acks.
   - Reordered input 0x411111 to chan1 is accepted while chan0 is full.
4. Head 0x8A0015, then tail 0xC0BEEF -> BD_v = 1 with leaf_code = 10 and payload = 0x15BEEF. With BD_a = 0, a second head+tail pair stalls on the tail only.
5. Error cases:
   - Tail 0xC00001 in IDLE -> consumed, BD_v stays 0, parse_err = 1.
   - Separately, 0x280000 (reg 40) -> dropped, parse_err = 1.
   - Separately, 0x420000 (chan 2) -> dropped, parse_err = 1.
6. Head 0x8A0015, reset pulse, then tail 0xC0BEEF -> BD_v stays 0, parse_err = 1, registers back at their reset values.
